multicast_fanout_tree: RTL and testbench



---
 rtl/multicast_fanout_tree.sv | 155 +++++++++++++++
 tb/tb_multicast_fanout_tree.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicast_fanout_tree.sv
// Buffered 1-to-FAN_OUT multicast tree: root register -> L1_N group FIFOs -> per-port leaf registers.
// Optional FANOUT_MASK_EN adds the in_mask port; without it every flit is broadcast to all outputs.
module multicast_fanout_tree #(
  parameter int FAN_OUT   = 54,
  parameter int L1_N      = 18,
  parameter int BUF_DEPTH = 2,
  parameter int FLIT_SIZE = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FLIT_SIZE-1:0]         in,
  input  logic                         in_valid,
`ifdef FANOUT_MASK_EN
  input  logic [FAN_OUT-1:0]           in_mask,
`endif
  output logic                         in_avail,
  output logic [FLIT_SIZE*FAN_OUT-1:0] out,
  output logic [FAN_OUT-1:0]           out_valid,
  input  logic [FAN_OUT-1:0]           out_avail
);
  localparam int L1_W = FAN_OUT / L1_N;
  localparam int PW   = $clog2(BUF_DEPTH);
  localparam int CW   = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(BUF_DEPTH);

  logic [FLIT_SIZE-1:0] r_root_flit;
  logic [FAN_OUT-1:0]   r_root_mask;
  logic [FLIT_SIZE-1:0] r_fifo_flit [L1_N][BUF_DEPTH];
  logic [L1_W-1:0]      r_fifo_mask [L1_N][BUF_DEPTH];
  logic [PW-1:0]        r_wptr [L1_N];
  logic [PW-1:0]        r_rptr [L1_N];
  logic [CW-1:0]        r_cnt  [L1_N];
  logic [FAN_OUT-1:0]   r_leaf_valid;
  logic [FLIT_SIZE-1:0] r_leaf_flit [FAN_OUT];

  logic [FAN_OUT-1:0]   w_in_mask;
  logic [FAN_OUT-1:0]   w_leaf_free;
  logic [FAN_OUT-1:0]   w_leaf_load;
  logic [FAN_OUT-1:0]   w_root_mask_nxt;
  logic [L1_W-1:0]      w_head_mask [L1_N];
  logic [L1_W-1:0]      w_head_mask_nxt [L1_N];
  logic [FLIT_SIZE-1:0] w_head_flit [L1_N];
  logic [L1_N-1:0]      w_head_vld;
  logic [L1_N-1:0]      w_pop;
  logic [L1_N-1:0]      w_push;
  logic                 w_root_retire;
  logic                 w_accept;

`ifdef FANOUT_MASK_EN
  assign w_in_mask = in_mask;
`else
  assign w_in_mask = {FAN_OUT{1'b1}};
`endif

  // A leaf can take a new flit when empty or handing its current one off this cycle.
  assign w_leaf_free = ~r_leaf_valid | out_avail;

  // Per-group head fan-out, FIFO pop/push decisions and root residual update.
  always_comb begin
    w_leaf_load     = '0;
    w_pop           = '0;
    w_push          = '0;
    w_head_vld      = '0;
    w_root_mask_nxt = r_root_mask;
    for (int g = 0; g < L1_N; g++) begin
      w_head_vld[g]  = (r_cnt[g] != '0);
      w_head_mask[g] = r_fifo_mask[g][r_rptr[g]];
      w_head_flit[g] = r_fifo_flit[g][r_rptr[g]];
      for (int k = 0; k < L1_W; k++) begin
        if (w_head_vld[g] && w_head_mask[g][k] && w_leaf_free[g*L1_W+k]) begin
          w_leaf_load[g*L1_W+k] = 1'b1;
        end else begin
          w_leaf_load[g*L1_W+k] = 1'b0;
        end
      end
      w_head_mask_nxt[g] = w_head_mask[g] & ~w_leaf_load[g*L1_W +: L1_W];
      w_pop[g] = w_head_vld[g] && (w_head_mask_nxt[g] == '0);
      // A full FIFO still takes a push in the cycle its head pops.
      if ((r_root_mask[g*L1_W +: L1_W] != '0) && ((r_cnt[g] != FULL_C) || w_pop[g])) begin
        w_push[g] = 1'b1;
        w_root_mask_nxt[g*L1_W +: L1_W] = '0;
      end else begin
        w_push[g] = 1'b0;
      end
    end
  end

  assign w_root_retire = (r_root_mask != '0) && (w_root_mask_nxt == '0);
  assign in_avail      = rst && ((r_root_mask == '0) || w_root_retire);
  assign w_accept      = in_valid && in_avail;
  assign out_valid     = r_leaf_valid;

  // Pack leaf registers onto the flat output bus.
  always_comb begin
    out = '0;
    for (int j = 0; j < FAN_OUT; j++) begin
      out[j*FLIT_SIZE +: FLIT_SIZE] = r_leaf_flit[j];
    end
  end

  // Root, group FIFO and leaf state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_root_flit  <= '0;
      r_root_mask  <= '0;
      r_leaf_valid <= '0;
      for (int g = 0; g < L1_N; g++) begin
        r_wptr[g] <= '0;
        r_rptr[g] <= '0;
        r_cnt[g]  <= '0;
        for (int d = 0; d < BUF_DEPTH; d++) begin
          r_fifo_flit[g][d] <= '0;
          r_fifo_mask[g][d] <= '0;
        end
      end
      for (int j = 0; j < FAN_OUT; j++) begin
        r_leaf_flit[j] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_root_flit <= in;
        r_root_mask <= w_in_mask;
      end else begin
        r_root_mask <= w_root_mask_nxt;
      end
      for (int g = 0; g < L1_N; g++) begin
        // Head residual update first; a simultaneous push into the same slot overrides it.
        if (w_head_vld[g]) begin
          r_fifo_mask[g][r_rptr[g]] <= w_head_mask_nxt[g];
        end
        if (w_push[g]) begin
          r_fifo_flit[g][r_wptr[g]] <= r_root_flit;
          r_fifo_mask[g][r_wptr[g]] <= r_root_mask[g*L1_W +: L1_W];
          r_wptr[g] <= r_wptr[g] + PW'(1);
        end
        if (w_pop[g]) begin
          r_rptr[g] <= r_rptr[g] + PW'(1);
        end
        case ({w_push[g], w_pop[g]})
          2'b10:   r_cnt[g] <= r_cnt[g] + CW'(1);
          2'b01:   r_cnt[g] <= r_cnt[g] - CW'(1);
          default: r_cnt[g] <= r_cnt[g];
        endcase
        for (int k = 0; k < L1_W; k++) begin
          if (w_leaf_load[g*L1_W+k]) begin
            r_leaf_valid[g*L1_W+k] <= 1'b1;
            r_leaf_flit[g*L1_W+k]  <= w_head_flit[g];
          end else if (out_avail[g*L1_W+k]) begin
            r_leaf_valid[g*L1_W+k] <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_multicast_fanout_tree.sv
// Self-checking bench for multicast_fanout_tree: per-port FIFO scoreboard plus directed latency/stall checks.
module tb_multicast_fanout_tree;
  localparam int FO = 54;
  localparam int FS = 8;
  localparam int SBD = 2048;

  logic             clk = 1'b0;
  logic             rst;
  logic [FS-1:0]    tb_in;
  logic             tb_in_valid;
  logic             in_avail;
  logic [FS*FO-1:0] out;
  logic [FO-1:0]    out_valid;
  logic [FO-1:0]    out_avail;
`ifdef FANOUT_MASK_EN
  logic [FO-1:0]    tb_mask;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [FS-1:0] sb [FO][SBD];
  int hd [FO];
  int tl [FO];
  int del_cnt [FO];
  int n_acc = 0;
  bit last_acc;

  always #5 clk = ~clk;

  multicast_fanout_tree #(.FAN_OUT(FO), .L1_N(18), .BUF_DEPTH(2), .FLIT_SIZE(FS)) dut (
    .clk(clk),
    .rst(rst),
    .in(tb_in),
    .in_valid(tb_in_valid),
`ifdef FANOUT_MASK_EN
    .in_mask(tb_mask),
`endif
    .in_avail(in_avail),
    .out(out),
    .out_valid(out_valid),
    .out_avail(out_avail)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit sb_empty();
    for (int j = 0; j < FO; j++) begin
      if (hd[j] != tl[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Observe handshakes at the falling edge, then advance past the next rising edge.
  task automatic cycle();
    @(negedge clk);
    last_acc = 1'b0;
    if (!rst) begin
      for (int j = 0; j < FO; j++) hd[j] = tl[j];
      chk("in_avail_in_reset", 512'(in_avail), 512'(0));
    end else begin
      for (int j = 0; j < FO; j++) begin
        if (out_valid[j]) begin
          chk($sformatf("port%0d_has_expected", j), 512'(hd[j] != tl[j]), 512'(1));
          if (hd[j] != tl[j]) begin
            chk($sformatf("port%0d_data", j), 512'(out[j*FS +: FS]), 512'(sb[j][hd[j] % SBD]));
            if (out_avail[j]) begin
              hd[j]++;
              del_cnt[j]++;
            end
          end
        end
      end
      last_acc = tb_in_valid && in_avail;
      if (last_acc) begin
        n_acc++;
        for (int j = 0; j < FO; j++) begin
`ifdef FANOUT_MASK_EN
          if (tb_mask[j]) begin
`else
          if (1'b1) begin
`endif
            sb[j][tl[j] % SBD] = tb_in;
            tl[j]++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    tb_in_valid = 1'b0;
    out_avail   = '1;
    for (int c = 0; c < 60 && !sb_empty(); c++) cycle();
    chk(tag, 512'(sb_empty()), 512'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [FS-1:0] f [6];
    logic [63:0]   r_a;
    logic [63:0]   r_b;
    int k, d0, d5, a0;
    int dp [FO];
    for (int j = 0; j < FO; j++) begin
      hd[j] = 0; tl[j] = 0; del_cnt[j] = 0;
    end
    rst = 1'b0; tb_in_valid = 1'b0; tb_in = '0; out_avail = '1;
`ifdef FANOUT_MASK_EN
    tb_mask = '1;
`endif
    cycle(); cycle();
    rst = 1'b1;
    chk("reset_out_valid", 512'(out_valid), 512'(0));
    chk("reset_out", 512'(out), 512'(0));

    // Single broadcast: visible after the second edge following acceptance, gone one cycle later.
    tb_in = 8'hA5; tb_in_valid = 1'b1;
    cycle();
    chk("bc_accept", 512'(last_acc), 512'(1));
    tb_in_valid = 1'b0;
    chk("bc_lat0", 512'(out_valid), 512'(0));
    cycle();
    chk("bc_lat1", 512'(out_valid), 512'(0));
    cycle();
    chk("bc_valid", 512'(out_valid), 512'({FO{1'b1}}));
    chk("bc_data", 512'(out), 512'({FO{8'hA5}}));
    cycle();
    chk("bc_fall", 512'(out_valid), 512'(0));
    drain("bc_drain");

`ifdef FANOUT_MASK_EN
    tb_mask = '0; tb_mask[0] = 1'b1; tb_mask[4] = 1'b1; tb_mask[53] = 1'b1;
    tb_in = 8'h3C; tb_in_valid = 1'b1;
    cycle();
    tb_in_valid = 1'b0;
    cycle(); cycle();
    chk("sparse_valid", 512'(out_valid), 512'(tb_mask));
    cycle();
    chk("sparse_fall", 512'(out_valid), 512'(0));
    tb_mask = '1;
    drain("sparse_drain");
`endif

    // Port 5 stalled: group 1 fills (1 leaf + 2 FIFO), root blocks on the 4th flit.
    for (int i = 0; i < 6; i++) f[i] = 8'h10 + 8'(i);
    d0 = del_cnt[0]; d5 = del_cnt[5];
    out_avail = '1; out_avail[5] = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      tb_in_valid = (k < 6); tb_in = f[k % 6];
      cycle();
      if (last_acc) k++;
    end
    chk("stall_accepted", 512'(k), 512'(4));
    chk("stall_port0_count", 512'(del_cnt[0] - d0), 512'(4));
    chk("stall_port5_hold", 512'({out_valid[5], out[5*FS +: FS]}), 512'({1'b1, 8'h10}));
    tb_in_valid = 1'b1; tb_in = f[k % 6];
    #1;
    chk("stall_in_avail", 512'(in_avail), 512'(0));
    out_avail = '1;
    for (int c = 0; c < 40 && (k < 6 || !sb_empty()); c++) begin
      tb_in_valid = (k < 6); tb_in = f[k % 6];
      cycle();
      if (last_acc) k++;
    end
    tb_in_valid = 1'b0;
    chk("stall_all_accepted", 512'(k), 512'(6));
    chk("stall_port5_count", 512'(del_cnt[5] - d5), 512'(6));
    chk("stall_port0_total", 512'(del_cnt[0] - d0), 512'(6));
    drain("stall_drain");

    // Streaming at one flit per cycle.
    a0 = n_acc;
    for (int i = 0; i < 100; i++) begin
      tb_in_valid = 1'b1; tb_in = 8'($urandom);
      #1;
      chk("stream_in_avail", 512'(in_avail), 512'(1));
      cycle();
      if (i >= 2) chk("stream_valid", 512'(out_valid), 512'({FO{1'b1}}));
    end
    tb_in_valid = 1'b0;
    cycle();
    chk("stream_tail1", 512'(out_valid), 512'({FO{1'b1}}));
    cycle();
    chk("stream_tail2", 512'(out_valid), 512'({FO{1'b1}}));
    cycle();
    chk("stream_end", 512'(out_valid), 512'(0));
    chk("stream_accepts", 512'(n_acc - a0), 512'(100));
    drain("stream_drain");

`ifdef FANOUT_MASK_EN
    tb_mask = '0; tb_in = 8'h77; tb_in_valid = 1'b1;
    cycle();
    chk("zero_accept", 512'(last_acc), 512'(1));
    tb_in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("zero_no_valid", 512'(out_valid), 512'(0));
      chk("zero_in_avail", 512'(in_avail), 512'(1));
      cycle();
    end
    tb_mask = '1;
`endif

    // Mid-operation reset with FIFOs holding data.
    out_avail = '1; out_avail[5] = 1'b0; out_avail[20] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tb_in_valid = 1'b1; tb_in = 8'hC0 + 8'(c);
      cycle();
    end
    tb_in_valid = 1'b0;
    rst = 1'b0;
    cycle();
    chk("mrst_valid", 512'(out_valid), 512'(0));
    chk("mrst_out", 512'(out), 512'(0));
    chk("mrst_in_avail", 512'(in_avail), 512'(0));
    rst = 1'b1; out_avail = '1;
    cycle(); cycle(); cycle();
    chk("mrst_no_stale", 512'(out_valid), 512'(0));
    for (int c = 0; c < 3; c++) begin
      tb_in_valid = 1'b1; tb_in = 8'h5A + 8'(c);
      cycle();
    end
    drain("mrst_drain");

    // Random traffic with random backpressure.
    for (int j = 0; j < FO; j++) dp[j] = del_cnt[j];
    a0 = n_acc;
    for (int c = 0; c < 400; c++) begin
      r_a = {$urandom, $urandom}; r_b = {$urandom, $urandom};
      tb_in_valid = ($urandom_range(0, 3) != 0);
      tb_in = 8'($urandom);
      out_avail = r_a[FO-1:0] | r_b[FO-1:0];
`ifdef FANOUT_MASK_EN
      r_a = {$urandom, $urandom};
      tb_mask = ($urandom_range(0, 7) == 0) ? '0 : r_a[FO-1:0];
`endif
      cycle();
    end
    drain("rand_drain");
    chk("rand_some_accepts", 512'(n_acc - a0 > 50), 512'(1));
`ifndef FANOUT_MASK_EN
    for (int j = 0; j < FO; j++) begin
      chk($sformatf("rand_port%0d_count", j), 512'(del_cnt[j] - dp[j]), 512'(n_acc - a0));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
